// File: rtl/seg_pkg.sv
// Shared types and the hex pattern table for the 7-segment readback path.
// Patterns are active-low with bit0 = segment a through bit6 = segment g.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Index is the hex value the pattern displays.
  localparam seg_t SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    WAIT,
    PEND,
    DONE
  } state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of an active-low 7-segment pattern into a hex digit.
// Blank is reported separately; anything outside the table is flagged as an error
// with digit forced to zero.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] digit_o,
  output logic       is_blank_o,
  output logic       is_err_o
);

  // Table lookup; at most one entry can match since the patterns are distinct.
  always_comb begin
    digit_o    = 4'h0;
    is_blank_o = (seg_i == SEG_BLANK);
    is_err_o   = (seg_i != SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_HEX[i]) begin
        digit_o  = 4'(i);
        is_err_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_reader.sv
// Recovers the hex digit shown on an asynchronous active-low 7-segment bus.
// The bus is synchronised, must hold a pattern for STABLE_CYCLES synchronised cycles,
// and each newly shown non-blank pattern is emitted once on a valid/ready stream.
// Optional build macro SEG_READER_ERRCNT_EN adds a saturating illegal-event counter.
module seg_reader
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic [6:0] out_raw
`ifdef SEG_READER_ERRCNT_EN
  ,
  input  logic       err_clear,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

  seg_t       sync1_q, seg_s_q, cand_q;
  seg_t       last_shown_q, last_shown_d;
  seg_t       out_raw_q, out_raw_d;
  logic [3:0] out_digit_q, out_digit_d;
  logic       out_err_q, out_err_d;
  logic [7:0] cnt_q;
  state_t     state_q, state_d;
  logic       stable;
  logic [3:0] dec_digit;
  logic       dec_blank, dec_err;

  seg_pattern_decode u_decode (
    .seg_i     (cand_q),
    .digit_o   (dec_digit),
    .is_blank_o(dec_blank),
    .is_err_o  (dec_err)
  );

  // Two-flop synchroniser and stability tracker; runs regardless of FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= SEG_BLANK;
      seg_s_q <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= seg;
      seg_s_q <= sync1_q;
      if (seg_s_q != cand_q) begin
        cand_q <= seg_s_q;
        cnt_q  <= 8'd0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign stable = (cnt_q == CntMax) && (seg_s_q == cand_q);

  // FSM state and the latched event fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT;
      last_shown_q <= SEG_BLANK;
      out_raw_q    <= SEG_BLANK;
      out_digit_q  <= 4'h0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_shown_q <= last_shown_d;
      out_raw_q    <= out_raw_d;
      out_digit_q  <= out_digit_d;
      out_err_q    <= out_err_d;
    end
  end

  // Next-state: event fields only change when leaving WAIT, so PEND holds them.
  always_comb begin
    state_d      = state_q;
    last_shown_d = last_shown_q;
    out_raw_d    = out_raw_q;
    out_digit_d  = out_digit_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      WAIT: begin
        if (stable && (cand_q != last_shown_q)) begin
          last_shown_d = cand_q;
          if (dec_blank) begin
            state_d = DONE;
          end else begin
            out_raw_d   = cand_q;
            out_digit_d = dec_digit;
            out_err_d   = dec_err;
            state_d     = PEND;
          end
        end
      end
      PEND: begin
        if (out_ready) begin
          state_d = WAIT;
        end
      end
      DONE: begin
        if (seg_s_q != last_shown_q) begin
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  assign out_valid = (state_q == PEND);
  assign out_digit = out_digit_q;
  assign out_err   = out_err_q;
  assign out_raw   = out_raw_q;

`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_count_q;

  // Count accepted illegal events; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (err_clear) begin
      err_count_q <= 8'd0;
    end else if (out_valid && out_ready && out_err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Self-checking bench for seg_reader: directed sequences, a pattern table and a
// randomized run, all checked against a cycle-level behavioural reference.
module tb_seg_reader;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_err;
  logic [6:0] out_raw;
`ifdef SEG_READER_ERRCNT_EN
  logic       err_clear = 1'b0;
  logic [7:0] err_count;
  int         m_ecnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_reader #(.STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .seg      (seg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_digit(out_digit),
    .out_err  (out_err),
    .out_raw  (out_raw)
`ifdef SEG_READER_ERRCNT_EN
    ,
    .err_clear(err_clear),
    .err_count(err_count)
`endif
  );

  // Reference model: run length of identical synchronised samples, last pattern
  // shown, and whether an event is pending or a blank is being held.
  logic [6:0] m_s1, m_ss, m_last, m_raw;
  int         m_run;
  bit         m_pend, m_blank, m_err;
  logic [3:0] m_dig;
  logic [11:0] evq[$];
  logic [6:0] pat_tab[16];

  typedef struct {
    logic [6:0] pat;
    bit         ev;
    logic [3:0] dig;
    bit         err;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] d, output bit e);
    e = 1'b0;
    case (p)
      7'b1000000: d = 4'h0;
      7'b1111001: d = 4'h1;
      7'b0100100: d = 4'h2;
      7'b0110000: d = 4'h3;
      7'b0011001: d = 4'h4;
      7'b0010010: d = 4'h5;
      7'b0000010: d = 4'h6;
      7'b1111000: d = 4'h7;
      7'b0000000: d = 4'h8;
      7'b0010000: d = 4'h9;
      7'b0001000: d = 4'hA;
      7'b0000011: d = 4'hB;
      7'b1000110: d = 4'hC;
      7'b0100001: d = 4'hD;
      7'b0000110: d = 4'hE;
      7'b0001110: d = 4'hF;
      default: begin
        d = 4'h0;
        e = 1'b1;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_s1    = 7'h7F;
    m_ss    = 7'h7F;
    m_last  = 7'h7F;
    m_raw   = 7'h7F;
    m_run   = 2;
    m_pend  = 1'b0;
    m_blank = 1'b0;
    m_err   = 1'b0;
    m_dig   = 4'h0;
`ifdef SEG_READER_ERRCNT_EN
    m_ecnt  = 0;
`endif
  endtask

  // A pattern counts as shown once S+1 consecutive synchronised samples agree.
  task automatic model_step(input logic [6:0] s, input bit r, input bit clr);
    bit         stable;
    logic [6:0] nss;
    stable = (m_run >= int'(S) + 1);
`ifdef SEG_READER_ERRCNT_EN
    if (clr) m_ecnt = 0;
    else if (m_pend && r && m_err && m_ecnt < 255) m_ecnt++;
`else
    if (clr) m_err = m_err;
`endif
    if (m_pend) begin
      if (r) m_pend = 1'b0;
    end else if (m_blank) begin
      if (m_ss != m_last) m_blank = 1'b0;
    end else if (stable && (m_ss != m_last)) begin
      m_last = m_ss;
      if (m_ss == 7'h7F) begin
        m_blank = 1'b1;
      end else begin
        m_pend = 1'b1;
        m_raw  = m_ss;
        ref_decode(m_ss, m_dig, m_err);
      end
    end
    nss  = m_s1;
    m_s1 = s;
    if (nss == m_ss) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 1;
    end
    m_ss = nss;
  endtask

  task automatic compare_model();
    check("valid", 32'(out_valid), 32'(m_pend));
    if (m_pend) begin
      check("digit", 32'(out_digit), 32'(m_dig));
      check("err", 32'(out_err), 32'(m_err));
      check("raw", 32'(out_raw), 32'(m_raw));
    end
`ifdef SEG_READER_ERRCNT_EN
    check("err_count", 32'(err_count), 32'(m_ecnt));
`endif
  endtask

  // One clock: capture pre-edge inputs/outputs, step the model, compare after the edge.
  task automatic tick();
    logic [6:0] s;
    bit         r, v, e, clr;
    logic [3:0] d;
    logic [6:0] w;
    s = seg;
    r = out_ready;
    v = out_valid;
    d = out_digit;
    e = out_err;
    w = out_raw;
    clr = 1'b0;
`ifdef SEG_READER_ERRCNT_EN
    clr = err_clear;
`endif
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (v && r) evq.push_back({e, d, w});
      model_step(s, r, clr);
    end
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    ticks(2);
    #3 reset = 1'b0;
    evq.delete();
  endtask

  // Ticks until out_valid; returns the number of edges taken (limit+1 on timeout).
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (n <= limit) begin
      tick();
      n++;
      if (out_valid) break;
    end
    if (!out_valid) n = limit + 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset state
    model_reset();
    #12 reset = 1'b0;
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_digit", 32'(out_digit), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_raw", 32'(out_raw), 32'h7F);

    // Single digit 1: latency and one-cycle pulse
    out_ready = 1'b1;
    seg = 7'b1111001;
    wait_valid(40, n);
    check("lat1", 32'(n), 32'(S + 3));
    check("d1_digit", 32'(out_digit), 32'h1);
    check("d1_err", 32'(out_err), 32'h0);
    check("d1_raw", 32'(out_raw), 32'h79);
    tick();
    check("d1_pulse", 32'(out_valid), 32'd0);
    ticks(10);
    check("d1_count", 32'(evq.size()), 32'd1);

    // Stream 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      seg = pat_tab[i];
      ticks(10);
    end
    check("stream_n", 32'(evq.size()), 32'd4);
    for (int i = 0; i < 4 && i < evq.size(); i++)
      check("stream_dig", 32'(evq[i][10:7]), 32'(i));

    // Glitch of 8 for two cycles inside a held 3
    ticks(4);
    evq.delete();
    seg = 7'b0000000;
    ticks(2);
    seg = pat_tab[3];
    ticks(14);
    check("glitch_n", 32'(evq.size()), 32'd0);

    // Illegal pattern
    seg = 7'b1010101;
    ticks(12);
    check("ill_n", 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      check("ill_err", 32'(evq[0][11]), 32'd1);
      check("ill_dig", 32'(evq[0][10:7]), 32'd0);
      check("ill_raw", 32'(evq[0][6:0]), 32'h55);
    end
`ifdef SEG_READER_ERRCNT_EN
    check("ill_cnt", 32'(err_count), 32'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("cnt_clear", 32'(err_count), 32'd0);
`endif

    // Backpressure: 5 held while bus moves to A
    out_ready = 1'b0;
    seg = pat_tab[5];
    ticks(10);
    check("bp_valid5", 32'(out_valid), 32'd1);
    check("bp_dig5", 32'(out_digit), 32'h5);
    seg = pat_tab[10];
    ticks(10);
    check("bp_hold_v", 32'(out_valid), 32'd1);
    check("bp_hold_d", 32'(out_digit), 32'h5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("bp_next_v", 32'(out_valid), 32'd1);
    check("bp_next_d", 32'(out_digit), 32'hA);
    out_ready = 1'b1;
    ticks(3);

    // Reset while 7 is pending
    out_ready = 1'b0;
    seg = pat_tab[7];
    wait_valid(40, n);
    check("p7_digit", 32'(out_digit), 32'h7);
    #1 reset = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_raw", 32'(out_raw), 32'h7F);
    model_reset();
    ticks(2);
    #3 reset = 1'b0;
    wait_valid(40, n);
    check("lat7", 32'(n), 32'(S + 3));
    check("re7_digit", 32'(out_digit), 32'h7);
    out_ready = 1'b1;
    ticks(3);

    // Pattern table
    vt.push_back('{7'h40, 1'b1, 4'h0, 1'b0});
    vt.push_back('{7'h79, 1'b1, 4'h1, 1'b0});
    vt.push_back('{7'h24, 1'b1, 4'h2, 1'b0});
    vt.push_back('{7'h30, 1'b1, 4'h3, 1'b0});
    vt.push_back('{7'h19, 1'b1, 4'h4, 1'b0});
    vt.push_back('{7'h12, 1'b1, 4'h5, 1'b0});
    vt.push_back('{7'h02, 1'b1, 4'h6, 1'b0});
    vt.push_back('{7'h78, 1'b1, 4'h7, 1'b0});
    vt.push_back('{7'h00, 1'b1, 4'h8, 1'b0});
    vt.push_back('{7'h10, 1'b1, 4'h9, 1'b0});
    vt.push_back('{7'h08, 1'b1, 4'hA, 1'b0});
    vt.push_back('{7'h03, 1'b1, 4'hB, 1'b0});
    vt.push_back('{7'h46, 1'b1, 4'hC, 1'b0});
    vt.push_back('{7'h21, 1'b1, 4'hD, 1'b0});
    vt.push_back('{7'h06, 1'b1, 4'hE, 1'b0});
    vt.push_back('{7'h0E, 1'b1, 4'hF, 1'b0});
    vt.push_back('{7'h7F, 1'b0, 4'h0, 1'b0});
    vt.push_back('{7'h0E, 1'b1, 4'hF, 1'b0});
    vt.push_back('{7'h55, 1'b1, 4'h0, 1'b1});
    vt.push_back('{7'h7F, 1'b0, 4'h0, 1'b0});
    vt.push_back('{7'h2A, 1'b1, 4'h0, 1'b1});
    do_reset();
    out_ready = 1'b1;
    foreach (vt[i]) begin
      evq.delete();
      seg = vt[i].pat;
      ticks(12);
      check("tab_n", 32'(evq.size()), 32'(vt[i].ev));
      if (vt[i].ev && evq.size() > 0) begin
        check("tab_dig", 32'(evq[0][10:7]), 32'(vt[i].dig));
        check("tab_err", 32'(evq[0][11]), 32'(vt[i].err));
        check("tab_raw", 32'(evq[0][6:0]), 32'(vt[i].pat));
      end
    end

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick <= 5) seg = pat_tab[$urandom_range(0, 15)];
      else if (pick == 6) seg = 7'h7F;
      else if (pick == 7) seg = 7'($urandom);
      for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
`ifdef SEG_READER_ERRCNT_EN
        err_clear = ($urandom_range(0, 40) == 0);
`endif
        tick();
      end
    end
`ifdef SEG_READER_ERRCNT_EN
    err_clear = 1'b0;
`endif
    out_ready = 1'b1;
    ticks(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
